// File: rtl/neuron_mac.sv
// Sequential MAC neuron: accumulates N_IN signed x*w products onto a bias,
// then emits a ReLU'd, shifted and clamped activation over valid/ready.
module neuron_mac #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ACC_W  = 20,
  parameter int unsigned N_IN   = 4,
  parameter int unsigned SHIFT  = 4
) (
  input  logic              clk,
  input  logic              clr_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] x,
  input  logic [DATA_W-1:0] w,
  input  logic [ACC_W-1:0]  bias,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] y,
  output logic              ovf
);

  localparam int unsigned CNT_W = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_IN - 1);
  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
  localparam logic [DATA_W-1:0] Y_MAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] Y_MAX_ACC = ACC_W'(Y_MAX);

  typedef enum logic [1:0] {S_ACC, S_ACT, S_OUT} state_e;

  state_e                   state_q, state_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic                     sticky_q, sticky_d;
  logic [DATA_W-1:0]        y_q, y_d;
  logic                     ovf_q, ovf_d;
  logic                     in_ready_q, in_ready_d;
  logic                     out_valid_q, out_valid_d;

  logic                       beat_c;
  logic                       first_c;
  logic                       last_c;
  logic signed [2*DATA_W-1:0] prod_c;
  logic signed [ACC_W-1:0]    prod_ext_c;
  logic signed [ACC_W-1:0]    base_c;
  logic signed [ACC_W:0]      sum_c;
  logic                       sat_c;
  logic signed [ACC_W-1:0]    shifted_c;

  // Datapath: one guard bit above the accumulator detects signed overflow.
  assign beat_c     = in_valid && in_ready_q;
  assign first_c    = (cnt_q == '0);
  assign last_c     = (cnt_q == CNT_LAST);
  assign prod_c     = $signed(x) * $signed(w);
  assign prod_ext_c = ACC_W'(prod_c);
  assign base_c     = first_c ? $signed(bias) : acc_q;
  assign sum_c      = (ACC_W+1)'(base_c) + (ACC_W+1)'(prod_ext_c);
  assign sat_c      = (sum_c[ACC_W] != sum_c[ACC_W-1]);
  assign shifted_c  = acc_q >>> SHIFT;

  // State and datapath registers.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q     <= S_ACC;
      cnt_q       <= '0;
      acc_q       <= '0;
      sticky_q    <= 1'b0;
      y_q         <= '0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      sticky_q    <= sticky_d;
      y_q         <= y_d;
      ovf_q       <= ovf_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_ACC:   if (beat_c && last_c) state_d = S_ACT;
      S_ACT:   state_d = S_OUT;
      S_OUT:   if (out_ready) state_d = S_ACC;
      default: state_d = S_ACC;
    endcase
  end

  // Datapath and registered-output next values.
  always_comb begin
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    sticky_d    = sticky_q;
    y_d         = y_q;
    ovf_d       = ovf_q;
    in_ready_d  = (state_d == S_ACC);
    out_valid_d = (state_d == S_OUT);
    unique case (state_q)
      S_ACC: begin
        if (beat_c) begin
          cnt_d    = last_c ? '0 : cnt_q + CNT_W'(1);
          acc_d    = sat_c ? (sum_c[ACC_W] ? ACC_MIN : ACC_MAX) : $signed(sum_c[ACC_W-1:0]);
          sticky_d = (first_c ? 1'b0 : sticky_q) | sat_c;
        end
      end
      S_ACT: begin
        if (acc_q[ACC_W-1]) begin
          y_d = '0;
        end else if ($unsigned(shifted_c) > Y_MAX_ACC) begin
          y_d = Y_MAX;
        end else begin
          y_d = shifted_c[DATA_W-1:0];
        end
        ovf_d = sticky_q;
      end
      default: ;
    endcase
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign y         = y_q;
  assign ovf       = ovf_q;

endmodule
